// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential 32-bit restoring divider (DIV/DIVU) for the E stage
//
// Purpose: radix-2 restoring divider, one quotient bit per cycle, with a
// combinational stall request so the pipeline stalls in the acceptance cycle.
// Optional build macro: DIV_EARLY_OUT_EN (one-cycle completion when |opa| < |opb|).
//
// Ports:
//   clk           - clock, rising-edge active
//   rst           - synchronous active-high reset
//   start_i       - divide valid in E stage, held while stalled
//   signed_i      - 1 = DIV (two's complement), 0 = DIVU
//   opa_i, opb_i  - dividend, divisor (sampled at acceptance)
//   annul_i       - flush/cancel of the E-stage divide
//   div_running_o - stall request to the hazard unit
//   ready_o       - one-cycle pulse, result_o valid
//   result_o      - {remainder, quotient}

module div_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        signed_i,
   input  logic [31:0] opa_i,
   input  logic [31:0] opb_i,
   input  logic        annul_i,
   output logic        div_running_o,
   output logic        ready_o,
   output logic [63:0] result_o
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

   stateT       state;
   logic [31:0] magB;      // divisor magnitude
   logic [31:0] quo;       // dividend shifts out of the top, quotient bits shift in
   logic [31:0] rem;       // partial remainder, always < magB between steps
   logic        negQ;
   logic        negR;
   logic [5:0]  count;

   logic [31:0] absA;
   logic [31:0] absB;
   logic [32:0] partial;
   logic        fits;
   logic [31:0] remNext;
   logic [31:0] quoNext;
   logic [31:0] quoFinal;
   logic [31:0] remFinal;

   always_comb begin
      absA = (signed_i && opa_i[31]) ? (32'd0 - opa_i) : opa_i;
      absB = (signed_i && opb_i[31]) ? (32'd0 - opb_i) : opb_i;

      // 33-bit trial value: remainder shifted left with the next dividend bit
      partial = {rem, quo[31]};
      fits    = (partial >= {1'b0, magB});
      // When it fits the difference is below magB, so 32-bit wrap-around is exact
      remNext = fits ? (partial[31:0] - magB) : partial[31:0];
      quoNext = {quo[30:0], fits};

      quoFinal = negQ ? (32'd0 - quoNext) : quoNext;
      remFinal = negR ? (32'd0 - remNext) : remNext;
   end

   // Stall is combinational so the request cycle itself already holds D/F/E
   always_comb begin
      div_running_o = ~rst & ~annul_i &
                      (((state == IDLE) & start_i) | (state == BUSY));
      ready_o       = ~rst & ~annul_i & (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         count    <= 6'd0;
         result_o <= 64'd0;
         rem      <= 32'd0;
         quo      <= 32'd0;
         magB     <= 32'd0;
         negQ     <= 1'b0;
         negR     <= 1'b0;
      end else if (annul_i) begin
         // Cancel wins over acceptance, stepping and completion
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  magB  <= absB;
                  quo   <= absA;
                  rem   <= 32'd0;
                  negQ  <= signed_i & (opa_i[31] ^ opb_i[31]);
                  negR  <= signed_i & opa_i[31];
                  count <= 6'd0;
                  if (opb_i == 32'd0) begin
                     result_o <= {opa_i, 32'hFFFF_FFFF};
                     state    <= DONE;
                  end
`ifdef DIV_EARLY_OUT_EN
                  else if (absA < absB) begin
                     // Quotient is zero and the remainder is the dividend itself
                     result_o <= {opa_i, 32'd0};
                     state    <= DONE;
                  end
`endif
                  else begin
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               rem   <= remNext;
               quo   <= quoNext;
               count <= count + 6'd1;
               if (count == 6'd31) begin
                  result_o <= {remFinal, quoFinal};
                  state    <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
